restoring_divider: RTL

Iterative unsigned radix-2 restoring divider; the inverse companion to the team's combinational Vedic multipliers. It accepts a WIDTH-bit dividend and divisor on a start pulse. It produces one quotient bit per clock and returns the quotient and remainder with a one-cycle done pulse. It is used wherever product/quotient pairs must be checked or undone, e.g. the multiplier self-check path.

---
 rtl/div_pkg.sv | 17 +
 rtl/div_step.sv | 31 +++
 rtl/restoring_divider.sv | 128 ++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
// Shared definitions for the restoring divider and the benches that reuse it.
//   DIV_WIDTH_DEFAULT : default operand width
//   div_state_e       : divider FSM states (IDLE / CALC / DONE)
// -----------------------------------------------------------------------------
package div_pkg;

    localparam int DIV_WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/div_step.sv
// -----------------------------------------------------------------------------
// div_step
// One combinational radix-2 restoring division step.
//   rem_i     : partial remainder (WIDTH+1 bits)
//   bit_i     : next dividend bit shifted into the remainder
//   divisor_i : divisor
//   rem_o     : next partial remainder
//   q_o       : quotient bit produced by this step
// -----------------------------------------------------------------------------
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic [WIDTH:0]   rem_i,
    input  logic             bit_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH:0]   rem_o,
    output logic             q_o
);

    // The remainder MSB is always 0 in normal operation (remainder < divisor),
    // but the compare uses the full shifted value so the step is exact for any
    // input rather than silently dropping a bit.
    logic [WIDTH+1:0] trial;

    assign trial = {rem_i, bit_i};
    assign q_o   = (trial >= {2'b00, divisor_i});
    assign rem_o = q_o ? (trial[WIDTH:0] - {1'b0, divisor_i}) : trial[WIDTH:0];

endmodule

// File: rtl/restoring_divider.sv
// -----------------------------------------------------------------------------
// restoring_divider
// Iterative unsigned radix-2 restoring divider, one quotient bit per clock.
//   clk, rst     : clock, synchronous active-high reset
//   start        : request, accepted in IDLE or DONE
//   dividend     : numerator, sampled on accept
//   divisor      : denominator, sampled on accept
//   busy         : high while iterating (WIDTH cycles)
//   done         : one-cycle pulse, results valid
//   quotient     : result, held until the next completion
//   remainder    : result, held until the next completion
//   div_by_zero  : divisor of the last completed operation was zero
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start
// CALC  | one restoring step per cycle, count = steps still to do
// DONE  | done pulse; a start here is accepted immediately (back-to-back)
// -----------------------------------------------------------------------------
module restoring_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    div_state_e       state_q,   state_d;
    logic [CW-1:0]    count_q,   count_d;
    logic [WIDTH-1:0] shreg_q,   shreg_d;
    logic [WIDTH-1:0] divisor_q, divisor_d;
    logic [WIDTH:0]   rem_q,     rem_d;
    logic [WIDTH-1:0] quot_q,    quot_d;
    logic [WIDTH-1:0] remout_q,  remout_d;
    logic             dbz_q,     dbz_d;

    logic [WIDTH:0]   step_rem;
    logic             step_q;

    // Dividend bits leave the shift register at the MSB while quotient bits
    // enter at the LSB, so one register serves as both.
    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i     (rem_q),
        .bit_i     (shreg_q[WIDTH-1]),
        .divisor_i (divisor_q),
        .rem_o     (step_rem),
        .q_o       (step_q)
    );

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        shreg_d   = shreg_q;
        divisor_d = divisor_q;
        rem_d     = rem_q;
        quot_d    = quot_q;
        remout_d  = remout_q;
        dbz_d     = dbz_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    shreg_d   = dividend;
                    divisor_d = divisor;
                    rem_d     = '0;
                    count_d   = CW'(WIDTH);
                    state_d   = CALC;
                end else begin
                    state_d   = IDLE;
                end
            end
            CALC: begin
                rem_d   = step_rem;
                shreg_d = {shreg_q[WIDTH-2:0], step_q};
                count_d = count_q - CW'(1);
                if (count_q == CW'(1)) begin
                    // Visible results only move here, so the previous result
                    // stays readable for the whole iteration.
                    state_d  = DONE;
                    quot_d   = {shreg_q[WIDTH-2:0], step_q};
                    remout_d = step_rem[WIDTH-1:0];
                    dbz_d    = (divisor_q == '0);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            count_q   <= '0;
            shreg_q   <= '0;
            divisor_q <= '0;
            rem_q     <= '0;
            quot_q    <= '0;
            remout_q  <= '0;
            dbz_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            shreg_q   <= shreg_d;
            divisor_q <= divisor_d;
            rem_q     <= rem_d;
            quot_q    <= quot_d;
            remout_q  <= remout_d;
            dbz_q     <= dbz_d;
        end
    end

    assign busy        = (state_q == CALC);
    assign done        = (state_q == DONE);
    assign quotient    = quot_q;
    assign remainder   = remout_q;
    assign div_by_zero = dbz_q;

endmodule
